// File: rtl/con_seq_pkg.sv
// rtl/con_seq_pkg.sv - shared types and encodings for the con_seq control sequencer.
// Optional IRQ state is compiled in with CON_SEQ_IRQ_EN.
package con_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_INW,
        S_HALT
`ifdef CON_SEQ_IRQ_EN
        ,
        S_IRQ
`endif
    } state_e;

    // Opcode values; the opcode field must be at least 4 bits wide to hold them.
    localparam int OP_MOVA  = 0;
    localparam int OP_MOVB  = 1;
    localparam int OP_MOVC  = 2;
    localparam int OP_ADD   = 3;
    localparam int OP_SUB   = 4;
    localparam int OP_AND   = 5;
    localparam int OP_NOT   = 6;
    localparam int OP_RSR   = 7;
    localparam int OP_RSL   = 8;
    localparam int OP_JMP   = 9;
    localparam int OP_JZ    = 10;
    localparam int OP_JC    = 11;
    localparam int OP_IN    = 12;
    localparam int OP_OUT   = 13;
    localparam int OP_NOP   = 14;
    localparam int OP_HALT  = 15;
    localparam int NUM_OPS  = 16;

    localparam logic [1:0] MADD_PC = 2'b00;
    localparam logic [1:0] MADD_RA = 2'b01;
    localparam logic [1:0] MADD_WA = 2'b10;

endpackage

// File: rtl/con_seq_dec.sv
// rtl/con_seq_dec.sv - combinational opcode to one-hot decode.
// Opcodes with no defined meaning decode to the NOP line.
module con_seq_dec
    import con_seq_pkg::*;
#(
    parameter int OPW = 4
) (
    input  logic [OPW-1:0]     i_op,
    output logic [NUM_OPS-1:0] o_oh
);

    logic [NUM_OPS-1:0] w_match;

    always_comb begin
        w_match = '0;
        for (int i = 0; i < NUM_OPS; i++) begin
            if (i_op == OPW'(i)) begin
                w_match[i] = 1'b1;
            end
        end
    end

    assign o_oh = (w_match == '0) ? (NUM_OPS'(1) << OP_NOP) : w_match;

endmodule

// File: rtl/con_seq.sv
// rtl/con_seq.sv - instruction control sequencer FSM driving datapath and memory strobes.
// Define CON_SEQ_IRQ_EN to add the irq input and the IRQ vectoring state.
module con_seq
    import con_seq_pkg::*;
#(
    parameter  int RN  = 4,
    parameter  int OPW = 4,
    localparam int RAW = $clog2(RN),
    localparam int IRW = OPW + 2 * RAW
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [IRW-1:0] ir,
    input  logic           z,
    input  logic           c,
    input  logic           mem_ack,
    input  logic           in_vld,
`ifdef CON_SEQ_IRQ_EN
    input  logic           irq,
    output logic           irq_ack,
    output logic           pc_vec_ld,
`endif
    output logic           mem_req,
    output logic           mem_rd,
    output logic           mem_wr,
    output logic [1:0]     madd,
    output logic           ir_ld,
    output logic           pc_inc,
    output logic           pc_ld,
    output logic           reg_we,
    output logic [RAW-1:0] reg_wa,
    output logic [RAW-1:0] reg_ra,
    output logic [OPW-1:0] alu_s,
    output logic           alu_m,
    output logic           cf_en,
    output logic           zf_en,
    output logic           shi_fbus,
    output logic           shi_frbus,
    output logic           shi_flbus,
    output logic           in_en,
    output logic           out_en,
    output logic           halted
);

    state_e             r_state;
    state_e             w_next;
    state_e             w_fetch_tgt;
    logic [OPW-1:0]     w_op;
    logic [NUM_OPS-1:0] w_oh;

    assign w_op = ir[IRW-1 -: OPW];

    con_seq_dec #(.OPW(OPW)) u_dec (
        .i_op (w_op),
        .o_oh (w_oh)
    );

    // Register addresses are all-zero while reset is held, like every other output.
    assign reg_wa = rst_n ? ir[2*RAW-1:RAW] : '0;
    assign reg_ra = rst_n ? ir[RAW-1:0]     : '0;

`ifdef CON_SEQ_IRQ_EN
    assign w_fetch_tgt = irq ? S_IRQ : S_FETCH;
`else
    assign w_fetch_tgt = S_FETCH;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        mem_req   = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        madd      = MADD_PC;
        ir_ld     = 1'b0;
        pc_inc    = 1'b0;
        pc_ld     = 1'b0;
        reg_we    = 1'b0;
        alu_s     = '0;
        alu_m     = 1'b0;
        cf_en     = 1'b0;
        zf_en     = 1'b0;
        shi_fbus  = 1'b0;
        shi_frbus = 1'b0;
        shi_flbus = 1'b0;
        in_en     = 1'b0;
        out_en    = 1'b0;
        halted    = 1'b0;
`ifdef CON_SEQ_IRQ_EN
        irq_ack   = 1'b0;
        pc_vec_ld = 1'b0;
`endif
        case (r_state)
            S_IDLE: w_next = w_fetch_tgt;
            S_FETCH: begin
                mem_req = 1'b1;
                mem_rd  = 1'b1;
                madd    = MADD_PC;
                if (mem_ack) begin
                    ir_ld  = 1'b1;
                    pc_inc = 1'b1;
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                w_next = w_fetch_tgt;
                case (1'b1)
                    w_oh[OP_ADD], w_oh[OP_SUB]: begin
                        reg_we   = 1'b1;
                        alu_m    = 1'b1;
                        shi_fbus = 1'b1;
                        alu_s    = w_op;
                        cf_en    = 1'b1;
                        zf_en    = 1'b1;
                    end
                    w_oh[OP_AND], w_oh[OP_NOT]: begin
                        reg_we   = 1'b1;
                        alu_m    = 1'b1;
                        shi_fbus = 1'b1;
                        alu_s    = w_op;
                    end
                    w_oh[OP_MOVA]: begin
                        reg_we   = 1'b1;
                        shi_fbus = 1'b1;
                    end
                    w_oh[OP_RSR]: begin
                        reg_we    = 1'b1;
                        cf_en     = 1'b1;
                        shi_frbus = 1'b1;
                    end
                    w_oh[OP_RSL]: begin
                        reg_we    = 1'b1;
                        cf_en     = 1'b1;
                        shi_flbus = 1'b1;
                    end
                    w_oh[OP_OUT]: begin
                        out_en   = 1'b1;
                        shi_fbus = 1'b1;
                    end
                    w_oh[OP_MOVB], w_oh[OP_MOVC], w_oh[OP_JMP]: w_next = S_MEM;
                    // A conditional jump that is not taken must still skip its address word.
                    w_oh[OP_JZ]: begin
                        if (z) w_next = S_MEM;
                        else   pc_inc = 1'b1;
                    end
                    w_oh[OP_JC]: begin
                        if (c) w_next = S_MEM;
                        else   pc_inc = 1'b1;
                    end
                    w_oh[OP_IN]:   w_next = S_INW;
                    w_oh[OP_HALT]: w_next = S_HALT;
                    w_oh[OP_NOP]:  w_next = w_fetch_tgt;
                    default:       w_next = w_fetch_tgt;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                if (w_oh[OP_MOVB]) begin
                    mem_rd = 1'b1;
                    madd   = MADD_RA;
                    reg_we = mem_ack;
                end else if (w_oh[OP_MOVC]) begin
                    mem_wr   = 1'b1;
                    madd     = MADD_WA;
                    shi_fbus = 1'b1;
                end else begin
                    mem_rd = 1'b1;
                    madd   = MADD_PC;
                    pc_ld  = mem_ack;
                end
                if (mem_ack) w_next = w_fetch_tgt;
            end
            S_INW: begin
                in_en = 1'b1;
                if (in_vld) begin
                    reg_we = 1'b1;
                    w_next = w_fetch_tgt;
                end
            end
            S_HALT: halted = 1'b1;
`ifdef CON_SEQ_IRQ_EN
            S_IRQ: begin
                irq_ack   = 1'b1;
                pc_vec_ld = 1'b1;
                w_next    = S_FETCH;
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_con_seq.sv
// tb/tb_con_seq.sv - randomized scoreboard bench for con_seq (IRQ checks when CON_SEQ_IRQ_EN is defined).
module tb_con_seq;
    import con_seq_pkg::*;

    localparam int RN  = 4;
    localparam int OPW = 4;
    localparam int RAW = 2;
    localparam int IRW = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [IRW-1:0] ir;
    logic           z, c, mem_ack, in_vld;
    logic           mem_req, mem_rd, mem_wr, ir_ld, pc_inc, pc_ld, reg_we;
    logic [1:0]     madd;
    logic [RAW-1:0] reg_wa, reg_ra;
    logic [OPW-1:0] alu_s;
    logic           alu_m, cf_en, zf_en, shi_fbus, shi_frbus, shi_flbus;
    logic           in_en, out_en, halted;
`ifdef CON_SEQ_IRQ_EN
    logic           irq, irq_ack, pc_vec_ld;
    bit             irq_in_exec = 1'b0;
`endif

    con_seq #(.RN(RN), .OPW(OPW)) dut (
        .clk(clk), .rst_n(rst_n), .ir(ir), .z(z), .c(c), .mem_ack(mem_ack), .in_vld(in_vld),
`ifdef CON_SEQ_IRQ_EN
        .irq(irq), .irq_ack(irq_ack), .pc_vec_ld(pc_vec_ld),
`endif
        .mem_req(mem_req), .mem_rd(mem_rd), .mem_wr(mem_wr), .madd(madd), .ir_ld(ir_ld),
        .pc_inc(pc_inc), .pc_ld(pc_ld), .reg_we(reg_we), .reg_wa(reg_wa), .reg_ra(reg_ra),
        .alu_s(alu_s), .alu_m(alu_m), .cf_en(cf_en), .zf_en(zf_en), .shi_fbus(shi_fbus),
        .shi_frbus(shi_frbus), .shi_flbus(shi_flbus), .in_en(in_en), .out_en(out_en),
        .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic           mem_req, mem_rd, mem_wr;
        logic [1:0]     madd;
        logic           ir_ld, pc_inc, pc_ld, reg_we;
        logic [RAW-1:0] reg_wa, reg_ra;
        logic [OPW-1:0] alu_s;
        logic           alu_m, cf_en, zf_en, fb, frb, flb, in_en, out_en, halted;
        logic           irq_ack, pc_vec_ld;
    } vec_t;

    vec_t           exp_q[$];
    string          name_q[$];
    int             checks = 0;
    int             errors = 0;
    logic [IRW-1:0] cur_ir;
    vec_t           mon_e, mon_a;
    string          mon_n;

    function automatic vec_t dut_vec();
        vec_t v = '0;
        v.mem_req = mem_req;  v.mem_rd = mem_rd;   v.mem_wr = mem_wr;  v.madd = madd;
        v.ir_ld   = ir_ld;    v.pc_inc = pc_inc;   v.pc_ld = pc_ld;    v.reg_we = reg_we;
        v.reg_wa  = reg_wa;   v.reg_ra = reg_ra;   v.alu_s = alu_s;    v.alu_m = alu_m;
        v.cf_en   = cf_en;    v.zf_en = zf_en;     v.fb = shi_fbus;    v.frb = shi_frbus;
        v.flb     = shi_flbus; v.in_en = in_en;    v.out_en = out_en;  v.halted = halted;
`ifdef CON_SEQ_IRQ_EN
        v.irq_ack = irq_ack;  v.pc_vec_ld = pc_vec_ld;
`endif
        return v;
    endfunction

    function automatic vec_t base(input logic [IRW-1:0] irv);
        vec_t e = '0;
        e.reg_wa = irv[3:2];
        e.reg_ra = irv[1:0];
        return e;
    endfunction

    // Expected EXEC-cycle strobes, straight from the instruction table.
    function automatic vec_t exp_exec(input int op, input logic [IRW-1:0] irv, input logic zz, input logic cc);
        vec_t e = base(irv);
        case (op)
            OP_ADD, OP_SUB: begin
                e.reg_we = 1; e.alu_m = 1; e.fb = 1; e.alu_s = 4'(op); e.cf_en = 1; e.zf_en = 1;
            end
            OP_AND, OP_NOT: begin
                e.reg_we = 1; e.alu_m = 1; e.fb = 1; e.alu_s = 4'(op);
            end
            OP_MOVA: begin e.reg_we = 1; e.fb = 1; end
            OP_RSR:  begin e.reg_we = 1; e.cf_en = 1; e.frb = 1; end
            OP_RSL:  begin e.reg_we = 1; e.cf_en = 1; e.flb = 1; end
            OP_OUT:  begin e.out_en = 1; e.fb = 1; end
            OP_JZ:   e.pc_inc = !zz;
            OP_JC:   e.pc_inc = !cc;
            default: ;
        endcase
        return e;
    endfunction

    function automatic vec_t exp_mem(input int op, input logic [IRW-1:0] irv, input logic ack);
        vec_t e = base(irv);
        e.mem_req = 1;
        if (op == OP_MOVB) begin
            e.mem_rd = 1; e.madd = 2'b01; e.reg_we = ack;
        end else if (op == OP_MOVC) begin
            e.mem_wr = 1; e.madd = 2'b10; e.fb = 1;
        end else begin
            e.mem_rd = 1; e.madd = 2'b00; e.pc_ld = ack;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_n = name_q.pop_front();
            mon_a = dut_vec();
            checks++;
            if (mon_a !== mon_e) begin
                errors++;
                $display("FAIL %s at %0t: got %h expected %h", mon_n, $time, mon_a, mon_e);
            end
        end
    end

    task automatic cyc(input vec_t e, input string n);
        exp_q.push_back(e);
        name_q.push_back(n);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mem_ack = 1'($urandom);
        in_vld = 1'($urandom);
        repeat (2) begin
            cur_ir = 8'($urandom);
            ir = cur_ir;
            cyc('0, "reset");
        end
        rst_n = 1'b1;
        mem_ack = 1'b1;
        in_vld = 1'b1;
        cyc(base(cur_ir), "idle");
        mem_ack = 1'b0;
        in_vld = 1'b0;
    endtask

    task automatic run_instr(input int op, input int wa, input int ra, input int fw, input int mw,
                             input logic zz, input logic cc, input bit abort);
        vec_t e;
        bit   to_mem;
        mem_ack = 1'b0;
        for (int i = 0; i < fw; i++) begin
            in_vld = 1'($urandom); z = 1'($urandom); c = 1'($urandom);
            e = base(cur_ir); e.mem_req = 1; e.mem_rd = 1;
            cyc(e, "fetch_wait");
        end
        mem_ack = 1'b1;
        in_vld = 1'($urandom);
        e = base(cur_ir); e.mem_req = 1; e.mem_rd = 1; e.ir_ld = 1; e.pc_inc = 1;
        cyc(e, "fetch_ack");

        cur_ir = {4'(op), 2'(wa), 2'(ra)};
        ir = cur_ir;
        mem_ack = 1'($urandom); in_vld = 1'($urandom); z = zz; c = cc;
`ifdef CON_SEQ_IRQ_EN
        irq = irq_in_exec;
`endif
        cyc(exp_exec(op, cur_ir, zz, cc), "exec");
`ifdef CON_SEQ_IRQ_EN
        irq = 1'b0;
        if (irq_in_exec) begin
            mem_ack = 1'b1;
            e = base(cur_ir); e.irq_ack = 1; e.pc_vec_ld = 1;
            cyc(e, "irq_vector");
        end
`endif
        z = 1'($urandom); c = 1'($urandom);
        to_mem = (op == OP_MOVB) || (op == OP_MOVC) || (op == OP_JMP) ||
                 (op == OP_JZ && zz) || (op == OP_JC && cc);
        if (to_mem) begin
            for (int i = 0; i < mw; i++) begin
                mem_ack = 1'b0; in_vld = 1'($urandom);
                cyc(exp_mem(op, cur_ir, 1'b0), "mem_wait");
            end
            if (abort) begin
                mem_ack = 1'b0;
                #2;
                rst_n = 1'b0;
                #1;
                checks++;
                if (mem_req !== 1'b0 || mem_wr !== 1'b0) begin
                    errors++;
                    $display("FAIL async_reset_mem: mem_req=%b mem_wr=%b required 0 0", mem_req, mem_wr);
                end
                cyc('0, "reset_abort");
                do_reset();
            end else begin
                mem_ack = 1'b1; in_vld = 1'($urandom);
                cyc(exp_mem(op, cur_ir, 1'b1), "mem_ack");
            end
        end else if (op == OP_IN) begin
            for (int i = 0; i < mw; i++) begin
                in_vld = 1'b0; mem_ack = 1'($urandom);
                e = base(cur_ir); e.in_en = 1;
                cyc(e, "inw_wait");
            end
            in_vld = 1'b1; mem_ack = 1'($urandom);
            e = base(cur_ir); e.in_en = 1; e.reg_we = 1;
            cyc(e, "inw_vld");
        end else if (op == OP_HALT) begin
            for (int i = 0; i < mw; i++) begin
                cur_ir = 8'($urandom); ir = cur_ir;
                mem_ack = 1'($urandom); in_vld = 1'($urandom);
                z = 1'($urandom); c = 1'($urandom);
                e = base(cur_ir); e.halted = 1;
                cyc(e, "halt_hold");
            end
        end
        mem_ack = 1'b0;
        in_vld = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; ir = '0; cur_ir = '0; z = 0; c = 0; mem_ack = 0; in_vld = 0;
`ifdef CON_SEQ_IRQ_EN
        irq = 1'b0;
`endif
        @(posedge clk);
        #1;
        do_reset();

        run_instr(OP_NOP, 0, 0, 3, 0, 0, 0, 0);
        run_instr(OP_ADD, 1, 2, 0, 0, 0, 0, 0);
        run_instr(OP_JZ,  3, 1, 1, 0, 0, 1, 0);
        run_instr(OP_JZ,  2, 0, 0, 2, 1, 0, 0);
        run_instr(OP_JC,  0, 3, 2, 0, 1, 0, 0);
        run_instr(OP_IN,  2, 3, 0, 5, 0, 0, 0);
        run_instr(OP_MOVB, 1, 3, 1, 3, 0, 0, 0);
        run_instr(OP_MOVC, 2, 1, 0, 1, 0, 0, 0);

        for (int n = 0; n < 150; n++) begin
            run_instr(int'($urandom_range(0, 14)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 0);
        end

        run_instr(OP_MOVC, 3, 2, 1, 2, 0, 0, 1);
        run_instr(OP_ADD, 2, 1, 0, 0, 0, 0, 0);
        run_instr(OP_HALT, 0, 0, 1, 100, 0, 0, 0);
        do_reset();
        run_instr(OP_SUB, 3, 3, 0, 0, 0, 0, 0);

`ifdef CON_SEQ_IRQ_EN
        irq_in_exec = 1'b1;
        run_instr(OP_NOP, 1, 1, 0, 0, 0, 0, 0);
        irq_in_exec = 1'b0;
        run_instr(OP_AND, 0, 1, 0, 0, 0, 0, 0);
`endif

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/con_seq.md
CON_SEQ -- requirements
Module: con_seq

Interface
REQ-001 Parameter RN, default 4, number of general registers (power of two, 2..16); RAW = clog2(RN).
REQ-002 Parameter OPW, default 4, opcode field width; IR width IRW = OPW + 2*RAW.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 ir  in  IRW  current instruction: opcode [IRW-1 -: OPW], wa [2*RAW-1:RAW], ra [RAW-1:0].
REQ-006 z, c  in  1 each  ALU zero and carry flags.
REQ-007 mem_ack  in  1  memory completes the current access this cycle.
REQ-008 in_vld  in  1  input device has data.
REQ-009 mem_req, mem_rd, mem_wr  out  1 each  memory request, read and write qualifiers.
REQ-010 madd  out  2  address select: 00 PC, 01 reg[ra], 10 reg[wa].
REQ-011 ir_ld, pc_inc, pc_ld, reg_we  out  1 each  IR load, PC increment, PC load, register write.
REQ-012 reg_wa, reg_ra  out  RAW each  register write/read addresses.
REQ-013 alu_s  out  OPW; alu_m, cf_en, zf_en  out  1 each  ALU mode and flag enables.
REQ-014 shi_fbus, shi_frbus, shi_flbus  out  1 each  shifter pass / right / left.
REQ-015 in_en, out_en, halted  out  1 each  input, output, halted indication.

Function
REQ-016 States SHALL be IDLE, FETCH, EXEC, MEM, INW, HALT.
REQ-017 IDLE SHALL move to FETCH after one cycle.
REQ-018 FETCH: mem_req=mem_rd=1, madd=00; on mem_ack: ir_ld=1, pc_inc=1, next EXEC; otherwise hold.
REQ-019 EXEC, ADD/SUB/AND/NOT: reg_we=1, alu_m=1, shi_fbus=1, alu_s=opcode, cf_en=1 (ADD/SUB), zf_en=1 (ADD/SUB); next FETCH.
REQ-020 EXEC, MOVA: reg_we=1, shi_fbus=1. RSR/RSL: reg_we=1, cf_en=1, shi_frbus or shi_flbus=1. OUT: out_en=1, shi_fbus=1. NOP: no strobes. Each of these: next FETCH.
REQ-021 EXEC, MOVB (load), MOVC (store), JMP, taken JZ/JC: next MEM. Not-taken JZ/JC: pc_inc=1 (skip the address word), next FETCH.
REQ-022 MEM, MOVB: mem_req=mem_rd=1, madd=01, reg_we=1 on the mem_ack cycle. MOVC: mem_req=mem_wr=1, madd=10, shi_fbus=1. Jump: mem_req=mem_rd=1, madd=00, pc_ld=1 on the mem_ack cycle. Next FETCH on mem_ack; otherwise hold.
REQ-023 EXEC, IN: next INW. INW: in_en=1; on in_vld: reg_we=1, next FETCH.
REQ-024 EXEC, HALT: next HALT. HALT SHALL be absorbing until reset, with halted=1 and all strobes 0.
REQ-025 reg_wa/reg_ra SHALL equal ir fields in every state; strobes are Moore outputs of state and ir, qualified by mem_ack/in_vld only where stated.
REQ-026 mem_ack or in_vld arriving in any state that does not wait on it SHALL be ignored.
REQ-027 Flags z/c SHALL be sampled only in EXEC.
REQ-028 Undefined opcodes SHALL behave as NOP.

Reset
REQ-029 While rst_n=0: state=IDLE and every output 0, including mem_req; a transaction in progress is abandoned immediately.

Configuration
REQ-030 With macro CON_SEQ_IRQ_EN defined: add ports irq (in, 1) and irq_ack, pc_vec_ld (out, 1 each). On any transition into FETCH with irq=1, the block SHALL enter state IRQ instead. IRQ asserts irq_ack=pc_vec_ld=1 for one cycle, then goes to FETCH.
REQ-031 Without CON_SEQ_IRQ_EN: those ports and the IRQ state SHALL be absent, and the behaviour SHALL be exactly as in REQ-016..029.

Structure
REQ-032 Package con_seq_pkg SHALL hold the state enum, the opcode localparams (MOVA..HALT) and the madd encodings.
REQ-033 Sub-module con_seq_dec SHALL be pure combinational opcode-to-one-hot decode; the FSM lives in con_seq.

Verification
REQ-034 Reset, then FETCH with mem_ack after 3 wait cycles: mem_req high 4 cycles, ir_ld=pc_inc=1 only on the ack cycle.
REQ-035 ADD ir=0x?6 (wa=1, ra=2): one EXEC cycle with reg_we=1, reg_wa=1, reg_ra=2, cf_en=zf_en=1; then FETCH.
REQ-036 JZ with z=0: pc_inc=1 in EXEC, no MEM state. JZ with z=1: MEM, pc_ld=1 on ack.
REQ-037 IN with in_vld low for 5 cycles: in_en held and no reg_we; reg_we=1 in the in_vld cycle.
REQ-038 rst_n low mid-MEM store: mem_req/mem_wr drop asynchronously, state IDLE; HALT then stays halted for 100 cycles.
REQ-039 CON_SEQ_IRQ_EN defined, irq=1 at NOP completion: exactly one cycle of irq_ack=pc_vec_ld=1 before FETCH.
